road_conflict_monitor: RTL

ROAD_CONFLICT_MONITOR -- requirements
Module: road_conflict_monitor

---
 rtl/road_conflict_monitor.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/road_conflict_monitor.sv
// Four-road signal conflict monitor: mirrors controller lamp states and falls back to a
// flashing-red failsafe on conflicts or illegal sequencing. Optional stall watchdog: CONFLICT_WATCHDOG_EN.
module road_conflict_monitor #(
  parameter int MIN_YELLOW     = 2,
  parameter int FLASH_HALF     = 1,
  parameter int ALLRED_TICKS   = 2,
  parameter int WATCHDOG_TICKS = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       timer,
  input  logic [1:0] road1_state,
  input  logic [1:0] road2_state,
  input  logic [1:0] road3_state,
  input  logic [1:0] road4_state,
  input  logic       clear_fault,
  output logic [1:0] road1_out,
  output logic [1:0] road2_out,
  output logic [1:0] road3_out,
  output logic [1:0] road4_out,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [1:0] ST_MONITOR = 2'd0;
  localparam logic [1:0] ST_FLASH   = 2'd1;
  localparam logic [1:0] ST_ALL_RED = 2'd2;

  localparam logic [1:0] LAMP_GREEN  = 2'b11;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;
  localparam logic [1:0] LAMP_RED    = 2'b01;
  localparam logic [1:0] LAMP_DARK   = 2'b00;

  localparam logic [3:0][1:0] ALL_RED_LAMPS  = {4{LAMP_RED}};
  localparam logic [3:0][1:0] ALL_DARK_LAMPS = {4{LAMP_DARK}};

  localparam logic [3:0] MIN_YEL_C    = 4'(MIN_YELLOW);
  localparam logic [7:0] FLASH_HALF_C = 8'(FLASH_HALF);
  localparam logic [7:0] ALLRED_C     = 8'(ALLRED_TICKS);
  localparam logic [7:0] WD_LIMIT_C   = 8'(WATCHDOG_TICKS);

  // Index 0 is road1 throughout.
  logic [3:0][1:0] cur_s;
  assign cur_s = {road4_state, road3_state, road2_state, road1_state};

  logic [1:0]       state_q, state_d;
  logic [3:0][1:0]  out_q, out_d;
  logic [3:0][1:0]  prev_q, prev_d;
  logic [3:0][2:0]  ycnt_q, ycnt_d;
  logic [7:0]       tick_cnt_q, tick_cnt_d;
  logic             flash_dark_q, flash_dark_d;
  logic             first_q, first_d;
  logic             fault_q, fault_d;
  logic [2:0]       fault_code_q, fault_code_d;

  logic [2:0] nonred_s;
  logic       conflict_s, invalid_s, bad_trans_s, short_yel_s, wd_hit_s;
  logic [2:0] det_code_s;
  logic [7:0] tick_inc_s;

  assign tick_inc_s = tick_cnt_q + {7'd0, timer};

`ifdef CONFLICT_WATCHDOG_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;

  // Stall counter: timer pulses since any road last changed while monitoring.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if ((state_q != ST_MONITOR) || first_q || (cur_s != prev_q)) begin
      wd_cnt_d = 8'd0;
    end else if (timer && (wd_cnt_q != 8'hFF)) begin
      wd_cnt_d = wd_cnt_q + 8'd1;
    end else begin
      wd_cnt_d = wd_cnt_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= 8'd0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign wd_hit_s = (state_q == ST_MONITOR) && (wd_cnt_q >= WD_LIMIT_C);
`else
  logic [7:0] unused_wd_limit_s;
  assign unused_wd_limit_s = WD_LIMIT_C;
  assign wd_hit_s          = 1'b0;
`endif

  // Combinational safety checks on the live inputs; transitions are skipped on the reload cycle.
  always_comb begin
    nonred_s    = 3'd0;
    invalid_s   = 1'b0;
    bad_trans_s = 1'b0;
    short_yel_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cur_s[i] != LAMP_RED) begin
        nonred_s = nonred_s + 3'd1;
      end else begin
        nonred_s = nonred_s;
      end
      if (cur_s[i] == LAMP_DARK) begin
        invalid_s = 1'b1;
      end else begin
        invalid_s = invalid_s;
      end
      if (!first_q) begin
        if (((prev_q[i] == LAMP_GREEN)  && (cur_s[i] == LAMP_RED))    ||
            ((prev_q[i] == LAMP_RED)    && (cur_s[i] == LAMP_YELLOW)) ||
            ((prev_q[i] == LAMP_YELLOW) && (cur_s[i] == LAMP_GREEN))) begin
          bad_trans_s = 1'b1;
        end else begin
          bad_trans_s = bad_trans_s;
        end
        if ((prev_q[i] == LAMP_YELLOW) && (cur_s[i] == LAMP_RED) &&
            ({1'b0, ycnt_q[i]} < MIN_YEL_C)) begin
          short_yel_s = 1'b1;
        end else begin
          short_yel_s = short_yel_s;
        end
      end else begin
        bad_trans_s = bad_trans_s;
        short_yel_s = short_yel_s;
      end
    end
  end

  assign conflict_s = (nonred_s > 3'd1);

  // Lowest fault code wins when several checks fire together.
  always_comb begin
    if (conflict_s) begin
      det_code_s = 3'd1;
    end else if (invalid_s) begin
      det_code_s = 3'd2;
    end else if (bad_trans_s) begin
      det_code_s = 3'd3;
    end else if (short_yel_s) begin
      det_code_s = 3'd4;
    end else if (wd_hit_s) begin
      det_code_s = 3'd5;
    end else begin
      det_code_s = 3'd0;
    end
  end

  // Next-state and output computation for the MONITOR / FLASH / ALL_RED machine.
  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    prev_d       = prev_q;
    ycnt_d       = ycnt_q;
    tick_cnt_d   = tick_cnt_q;
    flash_dark_d = flash_dark_q;
    first_d      = first_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    case (state_q)
      ST_MONITOR: begin
        prev_d  = cur_s;
        first_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (prev_q[i] != LAMP_YELLOW) begin
            ycnt_d[i] = 3'd0;
          end else if (timer && (ycnt_q[i] != 3'd7)) begin
            ycnt_d[i] = ycnt_q[i] + 3'd1;
          end else begin
            ycnt_d[i] = ycnt_q[i];
          end
        end
        if (det_code_s != 3'd0) begin
          // Faulty inputs are replaced by red, never forwarded.
          state_d      = ST_FLASH;
          out_d        = ALL_RED_LAMPS;
          fault_d      = 1'b1;
          fault_code_d = det_code_s;
          flash_dark_d = 1'b0;
          tick_cnt_d   = {7'd0, timer};
        end else begin
          out_d      = cur_s;
          tick_cnt_d = 8'd0;
        end
      end
      ST_FLASH: begin
        if (clear_fault) begin
          state_d      = ST_ALL_RED;
          out_d        = ALL_RED_LAMPS;
          flash_dark_d = 1'b0;
          tick_cnt_d   = {7'd0, timer};
        end else if (tick_inc_s >= FLASH_HALF_C) begin
          flash_dark_d = ~flash_dark_q;
          out_d        = flash_dark_q ? ALL_RED_LAMPS : ALL_DARK_LAMPS;
          tick_cnt_d   = 8'd0;
        end else begin
          tick_cnt_d = tick_inc_s;
        end
      end
      ST_ALL_RED: begin
        out_d = ALL_RED_LAMPS;
        if (tick_inc_s >= ALLRED_C) begin
          state_d      = ST_MONITOR;
          prev_d       = cur_s;
          ycnt_d       = 12'd0;
          fault_d      = 1'b0;
          fault_code_d = 3'd0;
          first_d      = 1'b1;
          tick_cnt_d   = 8'd0;
        end else begin
          tick_cnt_d = tick_inc_s;
        end
      end
      default: begin
        state_d    = ST_ALL_RED;
        out_d      = ALL_RED_LAMPS;
        tick_cnt_d = 8'd0;
      end
    endcase
  end

  // State registers; reset lands in the all-red hold with nothing latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ALL_RED;
      out_q        <= ALL_RED_LAMPS;
      prev_q       <= ALL_RED_LAMPS;
      ycnt_q       <= 12'd0;
      tick_cnt_q   <= 8'd0;
      flash_dark_q <= 1'b0;
      first_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      prev_q       <= prev_d;
      ycnt_q       <= ycnt_d;
      tick_cnt_q   <= tick_cnt_d;
      flash_dark_q <= flash_dark_d;
      first_q      <= first_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign road1_out  = out_q[0];
  assign road2_out  = out_q[1];
  assign road3_out  = out_q[2];
  assign road4_out  = out_q[3];
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule
